rca_pipe: RTL
=============

RCA_PIPE -- requirements
Module: rca_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/sum width in bits.
REQ-002 SHALL have parameter SEG, default 2, bits added per pipeline stage; NSTAGE = WIDTH/SEG.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, operand set present this cycle.
REQ-006 SHALL have ports x and y, input, WIDTH, unsigned addends.
REQ-007 SHALL have port cin, input, 1, carry into bit 0.
REQ-008 SHALL have port sat_en, input, 1, per-operation saturate mode (0 = wrap, 1 = saturate).
REQ-009 SHALL have port stall, input, 1, freezes the entire pipeline while high.
REQ-010 SHALL have port out_valid, output, 1, result present this cycle.
REQ-011 SHALL have port s, output, WIDTH, sum.
REQ-012 SHALL have port cout, output, 1, carry out of bit WIDTH-1.
REQ-013 SHALL have port ovf, output, 1, unsigned overflow flag (equals cout).

Function
REQ-014 SHALL compute {cout, raw} = x + y + cin modulo 2^(WIDTH+1).
REQ-015 SHALL add SEG bits per stage; the carry between segments is registered, giving NSTAGE segment stages.
REQ-016 SHALL skew input operands so that segment k uses operand bits captured with the same in_valid beat; upper-segment operand bits are delayed k cycles.
REQ-017 SHALL deskew sum segments so that all WIDTH bits of one operation appear together.
REQ-018 SHALL have latency exactly NSTAGE cycles from an accepted in_valid to out_valid, when stall is low throughout.
REQ-019 SHALL accept one operation per cycle (throughput 1) with no bubbles inserted.
REQ-020 SHALL deliver results strictly in input order.
REQ-021 SHALL, when sat_en = 0, output s = raw.
REQ-022 SHALL, when sat_en = 1 and cout = 1, output s = all ones; otherwise s = raw.
REQ-023 SHALL carry sat_en through the pipeline alongside its operation; changing sat_en affects only newly accepted operations.
REQ-024 SHALL, while stall = 1, hold every pipeline register (data, carries, valids) and all outputs unchanged, and ignore in_valid.
REQ-025 SHALL resume on stall deassertion with no loss, duplication or reordering.
REQ-026 SHALL drive s, cout and ovf to zero whenever out_valid = 0.
REQ-027 SHALL treat x, y, cin and sat_en as don't-care when in_valid = 0; they must not alter any output.
REQ-028 SHALL give rst priority over stall and in_valid when asserted in the same cycle.
REQ-029 SHALL fail elaboration when WIDTH % SEG != 0, when SEG < 1, or when WIDTH < SEG.
REQ-030 SHALL reduce to a single registered stage (latency 1) when SEG = WIDTH.

Reset
REQ-031 SHALL, on rst, clear all valid bits, inter-segment carries, skew registers and deskew registers.
REQ-032 SHALL have reset values out_valid = 0, s = 0, cout = 0, ovf = 0, visible the cycle after rst is sampled high.
REQ-033 SHALL discard any operations in flight at reset; none may emerge after reset deasserts.
REQ-034 SHALL accept in_valid on the first cycle rst is low.

Structure
REQ-035 SHALL take the stage-count function and the mode encodings (WRAP = 0, SAT = 1) from shared package vd_pkg.
REQ-036 SHALL instantiate sub-module rca_seg once per stage: a SEG-bit combinational ripple adder with inputs a, b, ci and outputs sum, co.
REQ-037 SHALL place the skew, deskew, valid and saturation logic in rca_pipe itself.

Verification
REQ-038 Scenario (WIDTH=8, SEG=2): x=0x3C, y=0x05, cin=0, sat_en=0 -> out_valid exactly 4 cycles later with s=0x41, cout=0, ovf=0.
REQ-039 Scenario: x=0xFF, y=0x01, cin=0, sat_en=0 -> s=0x00, cout=1, ovf=1; same operands with sat_en=1 -> s=0xFF, cout=1, ovf=1.
REQ-040 Scenario: 4 back-to-back ops (0x01+0x01, 0x7F+0x01, 0x80+0x80, 0xAA+0x55 with cin=1) -> 4 consecutive valid results 0x02, 0x80, 0x00/cout=1, 0x00/cout=1, in order.
REQ-041 Scenario: stall high for 3 cycles while 2 ops are in flight -> both results delayed by exactly 3 cycles, values unchanged, outputs frozen during the stall.
REQ-042 Scenario: rst asserted 2 cycles after an accepted op -> out_valid=0 from the next cycle on, and no result appears for that op.
REQ-043 Scenario: SEG=WIDTH=8, x=0x10, y=0x20 -> s=0x30 after 1 cycle.

Source files
------------

// File: rtl/vd_pkg.sv
// Shared definitions for the pipelined ripple-carry adder: mode encodings and stage-count helper.
package vd_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    // Number of SEG-bit segment stages; degenerate parameters map to 1 so elaboration reaches the check.
    function automatic int unsigned nstage(input int width, input int seg);
        if ((seg < 1) || (width < seg)) begin
            return 32'd1;
        end
        return 32'(width / seg);
    endfunction

endpackage

// File: rtl/rca_seg.sv
// Combinational SEG-bit ripple-carry adder segment.
module rca_seg
    import vd_pkg::*;
#(
    parameter int SEG = 2
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] sum,
    output logic           co
);

    logic w_c;

    always_comb begin
        sum = '0;
        w_c = ci;
        for (int i = 0; i < SEG; i++) begin
            sum[i] = a[i] ^ b[i] ^ w_c;
            w_c    = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
        end
        co = w_c;
    end

endmodule

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder: SEG bits per stage, registered inter-segment carries,
// operand skew / sum deskew, optional saturation, global stall.
module rca_pipe
    import vd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEG   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sat_en,
    input  logic             stall,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSTAGE = nstage(WIDTH, SEG);

    if ((SEG < 1) || (WIDTH < SEG) || ((WIDTH % ((SEG < 1) ? 1 : SEG)) != 0)) begin : g_param_check
        $error("rca_pipe: WIDTH must be a positive multiple of SEG");
    end

    // Stage j inputs (valid, carry) and segment carry-outs.
    logic [NSTAGE-1:0] w_vin;
    logic [NSTAGE-1:0] w_cin;
    logic [NSTAGE-1:0] w_co;
    // r_v[NSTAGE-1] / r_c[NSTAGE-1] double as out_valid / cout.
    logic [NSTAGE-1:0] r_v;
    logic [NSTAGE-1:0] r_c;
    logic [WIDTH-1:0]  w_raw;
    logic              w_sat;
    logic [WIDTH-1:0]  w_s_nxt;
    logic [WIDTH-1:0]  r_s;

    assign w_vin[0] = in_valid;
    assign w_cin[0] = cin;

    for (genvar j = 1; j < NSTAGE; j++) begin : g_link
        assign w_vin[j] = r_v[j-1];
        assign w_cin[j] = r_c[j-1];
    end

    // Carries are masked by valid so an empty slot never reports a carry-out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= '0;
            r_c <= '0;
        end else if (!stall) begin
            r_v <= w_vin;
            r_c <= w_co & w_vin;
        end
    end

    for (genvar j = 0; j < NSTAGE; j++) begin : g_seg
        logic [SEG-1:0] w_a;
        logic [SEG-1:0] w_b;
        logic [SEG-1:0] w_sum;

        if (j == 0) begin : g_direct
            assign w_a = x[SEG-1:0];
            assign w_b = y[SEG-1:0];
        end else begin : g_skew
            // Segment j operands wait j cycles so they meet their carry.
            logic [SEG-1:0] r_xd [j];
            logic [SEG-1:0] r_yd [j];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int d = 0; d < j; d++) begin
                        r_xd[d] <= '0;
                        r_yd[d] <= '0;
                    end
                end else if (!stall) begin
                    r_xd[0] <= x[j*SEG +: SEG];
                    r_yd[0] <= y[j*SEG +: SEG];
                    for (int d = 1; d < j; d++) begin
                        r_xd[d] <= r_xd[d-1];
                        r_yd[d] <= r_yd[d-1];
                    end
                end
            end

            assign w_a = r_xd[j-1];
            assign w_b = r_yd[j-1];
        end

        rca_seg #(.SEG(SEG)) u_seg (
            .a   (w_a),
            .b   (w_b),
            .ci  (w_cin[j]),
            .sum (w_sum),
            .co  (w_co[j])
        );

        if (j < NSTAGE - 1) begin : g_deskew
            localparam int unsigned DEPTH = NSTAGE - 1 - j;
            logic [SEG-1:0] r_sd [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int d = 0; d < int'(DEPTH); d++) begin
                        r_sd[d] <= '0;
                    end
                end else if (!stall) begin
                    r_sd[0] <= w_sum;
                    for (int d = 1; d < int'(DEPTH); d++) begin
                        r_sd[d] <= r_sd[d-1];
                    end
                end
            end

            assign w_raw[j*SEG +: SEG] = r_sd[DEPTH-1];
        end else begin : g_last
            assign w_raw[j*SEG +: SEG] = w_sum;
        end
    end

    // Saturate mode travels with its operation up to the final stage.
    if (NSTAGE > 1) begin : g_sat_pipe
        logic [NSTAGE-2:0] r_satd;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_satd <= '0;
            end else if (!stall) begin
                r_satd[0] <= sat_en;
                for (int i = 1; i < int'(NSTAGE) - 1; i++) begin
                    r_satd[i] <= r_satd[i-1];
                end
            end
        end

        assign w_sat = r_satd[NSTAGE-2];
    end else begin : g_sat_direct
        assign w_sat = sat_en;
    end

    always_comb begin
        w_s_nxt = '0;
        if (w_vin[NSTAGE-1]) begin
            if ((mode_e'(w_sat) == MODE_SAT) && w_co[NSTAGE-1]) begin
                w_s_nxt = '1;
            end else begin
                w_s_nxt = w_raw;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s <= '0;
        end else if (!stall) begin
            r_s <= w_s_nxt;
        end
    end

    assign out_valid = r_v[NSTAGE-1];
    assign s         = r_s;
    assign cout      = r_c[NSTAGE-1];
    assign ovf       = r_c[NSTAGE-1];

endmodule
